// File: rtl/writeback_register_file_if.sv
// Signal bundle between the MEM/WB pipeline boundary and the writeback register file.
// Also carries a retired-counter preload used by debug and test access.
interface writeback_register_file_if;
    logic        wb_valid_i;
    logic [31:0] data_read_i;
    logic [31:0] alu_result_i;
    logic [31:0] pc_plus4_i;
    logic [4:0]  write_reg_i;
    logic [1:0]  mem_to_reg_i;
    logic        reg_write_i;
    logic [2:0]  load_type_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        cnt_load_i;
    logic [31:0] cnt_load_val_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [31:0] retired_count_o;

    modport master (
        output wb_valid_i, data_read_i, alu_result_i, pc_plus4_i, write_reg_i,
               mem_to_reg_i, reg_write_i, load_type_i, rs1_addr_i, rs2_addr_i,
               cnt_load_i, cnt_load_val_i,
        input  rs1_data_o, rs2_data_o, wb_data_o, wb_we_o, retired_count_o
    );

    modport slave (
        input  wb_valid_i, data_read_i, alu_result_i, pc_plus4_i, write_reg_i,
               mem_to_reg_i, reg_write_i, load_type_i, rs1_addr_i, rs2_addr_i,
               cnt_load_i, cnt_load_val_i,
        output rs1_data_o, rs2_data_o, wb_data_o, wb_we_o, retired_count_o
    );
endinterface

// File: rtl/writeback_register_file.sv
// RV32I writeback stage: load alignment, writeback select, 32x32 register file
// with write-through bypass on both read ports, and a retired-instruction counter.
module writeback_register_file (
    input  logic                        clk_i,
    input  logic                        reset_i,
    writeback_register_file_if.slave    bus
);
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] retired_count_q;
    logic [31:0] retired_count_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    always_comb begin
        ld_byte = 8'h00;
        case (bus.alu_result_i[1:0])
            2'd0:    ld_byte = bus.data_read_i[7:0];
            2'd1:    ld_byte = bus.data_read_i[15:8];
            2'd2:    ld_byte = bus.data_read_i[23:16];
            default: ld_byte = bus.data_read_i[31:24];
        endcase
        // Misaligned halfwords are not trapped; only bit 1 picks the half.
        ld_half = bus.alu_result_i[1] ? bus.data_read_i[31:16] : bus.data_read_i[15:0];

        ld_data = 32'h0;
        case (bus.load_type_i)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LW:   ld_data = bus.data_read_i;
            LD_LBU:  ld_data = {24'h0, ld_byte};
            LD_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = 32'h0;
        endcase
    end

    always_comb begin
        wb_data = 32'h0;
        case (bus.mem_to_reg_i)
            WB_ALU:  wb_data = bus.alu_result_i;
            WB_LOAD: wb_data = ld_data;
            WB_LINK: wb_data = bus.pc_plus4_i;
            default: wb_data = 32'h0;
        endcase

        wb_we = bus.wb_valid_i & bus.reg_write_i & (bus.write_reg_i != 5'd0)
              & (bus.mem_to_reg_i != 2'b11) & ~reset_i;
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_d[i] = 32'h0;
            end
        end else if (wb_we) begin
            for (int i = 1; i < 32; i++) begin
                if (bus.write_reg_i == i[4:0]) begin
                    regs_d[i] = wb_data;
                end
            end
        end
        regs_d[0] = 32'h0;
    end

    always_comb begin
        retired_count_d = retired_count_q;
        if (reset_i) begin
            retired_count_d = 32'h0;
        end else if (bus.cnt_load_i) begin
            retired_count_d = bus.cnt_load_val_i;
        end else if (bus.wb_valid_i) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    // Bypass requires wb_we, which already excludes x0 and reset.
    always_comb begin
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        if (!reset_i) begin
            if (wb_we && (bus.rs1_addr_i == bus.write_reg_i)) begin
                rs1_data = wb_data;
            end else if (bus.rs1_addr_i != 5'd0) begin
                rs1_data = regs_q[bus.rs1_addr_i];
            end
            if (wb_we && (bus.rs2_addr_i == bus.write_reg_i)) begin
                rs2_data = wb_data;
            end else if (bus.rs2_addr_i != 5'd0) begin
                rs2_data = regs_q[bus.rs2_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
        end
        retired_count_q <= retired_count_d;
    end

    assign bus.rs1_data_o      = rs1_data;
    assign bus.rs2_data_o      = rs2_data;
    assign bus.wb_data_o       = wb_data;
    assign bus.wb_we_o         = wb_we;
    assign bus.retired_count_o = retired_count_q;
endmodule

// File: tb/tb_writeback_register_file.sv
// Directed bench for writeback_register_file: alignment, bypass, x0, counter, reset.
module tb_writeback_register_file;
    logic clk_i = 1'b0;
    logic reset_i;
    int   n_cmp = 0;
    int   n_err = 0;

    writeback_register_file_if wbif ();

    writeback_register_file dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (wbif.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        wbif.wb_valid_i     = 1'b0;
        wbif.data_read_i    = 32'h0;
        wbif.alu_result_i   = 32'h0;
        wbif.pc_plus4_i     = 32'h0;
        wbif.write_reg_i    = 5'd0;
        wbif.mem_to_reg_i   = 2'b00;
        wbif.reg_write_i    = 1'b0;
        wbif.load_type_i    = 3'b010;
        wbif.rs1_addr_i     = 5'd0;
        wbif.rs2_addr_i     = 5'd0;
        wbif.cnt_load_i     = 1'b0;
        wbif.cnt_load_val_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_write(input logic [4:0] rd, input logic [1:0] m2r, input logic [31:0] alu);
        wbif.wb_valid_i   = 1'b1;
        wbif.reg_write_i  = 1'b1;
        wbif.write_reg_i  = rd;
        wbif.mem_to_reg_i = m2r;
        wbif.alu_result_i = alu;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        idle();
        tick();
        tick();
        drive_write(5'd5, 2'b00, 32'hCAFE0001);
        wbif.rs1_addr_i = 5'd5;
        #1;
        n_cmp++;
        if (wbif.wb_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got=%0b exp=0", wbif.wb_we_o); end
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h0) begin n_err++; $display("FAIL reset_nobypass got=%h exp=0", wbif.rs1_data_o); end
        tick();
        reset_i = 1'b0;
        idle();
        wbif.rs1_addr_i = 5'd5;
        #1;
        n_cmp++;
        if (wbif.retired_count_o !== 32'h0) begin n_err++; $display("FAIL reset_count got=%h exp=0", wbif.retired_count_o); end
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h0) begin n_err++; $display("FAIL reset_x5 got=%h exp=0", wbif.rs1_data_o); end
    endtask

    task automatic test_basic_write();
        drive_write(5'd5, 2'b00, 32'hDEADBEEF);
        tick();
        idle();
        wbif.rs1_addr_i = 5'd5;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_x5 got=%h exp=deadbeef", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.retired_count_o !== 32'd1) begin n_err++; $display("FAIL basic_count got=%h exp=1", wbif.retired_count_o); end
    endtask

    task automatic test_load_align();
        logic [31:0] exp_lb  [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFF0, 32'hFFFFFF80};
        logic [31:0] exp_lbu [4] = '{32'h00000001, 32'h0000007F, 32'h000000F0, 32'h00000080};
        idle();
        wbif.mem_to_reg_i = 2'b01;
        wbif.data_read_i  = 32'h80F07F01;
        for (int off = 0; off < 4; off++) begin
            wbif.alu_result_i = 32'h00001000 + off;
            wbif.load_type_i  = 3'b000;
            #1;
            n_cmp++;
            if (wbif.wb_data_o !== exp_lb[off]) begin n_err++; $display("FAIL lb_off%0d got=%h exp=%h", off, wbif.wb_data_o, exp_lb[off]); end
            wbif.load_type_i = 3'b100;
            #1;
            n_cmp++;
            if (wbif.wb_data_o !== exp_lbu[off]) begin n_err++; $display("FAIL lbu_off%0d got=%h exp=%h", off, wbif.wb_data_o, exp_lbu[off]); end
        end
        wbif.alu_result_i = 32'h00001002;
        wbif.load_type_i  = 3'b001;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'hFFFF80F0) begin n_err++; $display("FAIL lh_off2 got=%h exp=ffff80f0", wbif.wb_data_o); end
        wbif.load_type_i = 3'b101;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h000080F0) begin n_err++; $display("FAIL lhu_off2 got=%h exp=000080f0", wbif.wb_data_o); end
        wbif.alu_result_i = 32'h00001001;
        wbif.load_type_i  = 3'b001;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h00007F01) begin n_err++; $display("FAIL lh_off1 got=%h exp=00007f01", wbif.wb_data_o); end
        wbif.alu_result_i = 32'h00001003;
        wbif.load_type_i  = 3'b010;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h80F07F01) begin n_err++; $display("FAIL lw_off3 got=%h exp=80f07f01", wbif.wb_data_o); end
        wbif.load_type_i = 3'b011;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h0) begin n_err++; $display("FAIL ld_bad011 got=%h exp=0", wbif.wb_data_o); end
        wbif.load_type_i = 3'b111;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h0) begin n_err++; $display("FAIL ld_bad111 got=%h exp=0", wbif.wb_data_o); end
        // Committed load: LB offset 3 into x6 (count 1 -> 2)
        drive_write(5'd6, 2'b01, 32'h00002003);
        wbif.load_type_i = 3'b000;
        tick();
        idle();
        wbif.rs2_addr_i = 5'd6;
        #1;
        n_cmp++;
        if (wbif.rs2_data_o !== 32'hFFFFFF80) begin n_err++; $display("FAIL load_x6 got=%h exp=ffffff80", wbif.rs2_data_o); end
    endtask

    task automatic test_x0_and_nowrite();
        drive_write(5'd0, 2'b00, 32'h12345678);
        wbif.rs2_addr_i = 5'd0;
        #1;
        n_cmp++;
        if (wbif.wb_we_o !== 1'b0) begin n_err++; $display("FAIL x0_we got=%0b exp=0", wbif.wb_we_o); end
        n_cmp++;
        if (wbif.rs2_data_o !== 32'h0) begin n_err++; $display("FAIL x0_bypass got=%h exp=0", wbif.rs2_data_o); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (wbif.rs2_data_o !== 32'h0) begin n_err++; $display("FAIL x0_read got=%h exp=0", wbif.rs2_data_o); end
        drive_write(5'd7, 2'b00, 32'h00000077);
        tick();
        drive_write(5'd7, 2'b11, 32'h00000BAD);
        #1;
        n_cmp++;
        if (wbif.wb_we_o !== 1'b0) begin n_err++; $display("FAIL m2r11_we got=%0b exp=0", wbif.wb_we_o); end
        n_cmp++;
        if (wbif.wb_data_o !== 32'h0) begin n_err++; $display("FAIL m2r11_data got=%h exp=0", wbif.wb_data_o); end
        tick();
        idle();
        wbif.rs1_addr_i = 5'd7;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h00000077) begin n_err++; $display("FAIL m2r11_x7 got=%h exp=00000077", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.retired_count_o !== 32'd5) begin n_err++; $display("FAIL count_after_x0 got=%h exp=5", wbif.retired_count_o); end
    endtask

    task automatic test_bypass();
        drive_write(5'd9, 2'b00, 32'hA5A5A5A5);
        wbif.rs1_addr_i = 5'd9;
        wbif.rs2_addr_i = 5'd9;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_rs1 got=%h exp=a5a5a5a5", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.rs2_data_o !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_rs2 got=%h exp=a5a5a5a5", wbif.rs2_data_o); end
        tick();
        drive_write(5'd9, 2'b00, 32'h11111111);
        wbif.rs1_addr_i = 5'd9;
        wbif.rs2_addr_i = 5'd5;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h11111111) begin n_err++; $display("FAIL bypass_split_rs1 got=%h exp=11111111", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.rs2_data_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_split_rs2 got=%h exp=deadbeef", wbif.rs2_data_o); end
        tick();
        idle();
        wbif.rs1_addr_i = 5'd9;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h11111111) begin n_err++; $display("FAIL bypass_x9_stored got=%h exp=11111111", wbif.rs1_data_o); end
    endtask

    task automatic test_jal_and_counter();
        drive_write(5'd1, 2'b10, 32'h0000F00D);
        wbif.pc_plus4_i = 32'h00000104;
        #1;
        n_cmp++;
        if (wbif.wb_data_o !== 32'h00000104) begin n_err++; $display("FAIL jal_wbdata got=%h exp=00000104", wbif.wb_data_o); end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            wbif.wb_valid_i   = 1'b1;
            wbif.write_reg_i  = 5'd1;
            wbif.alu_result_i = 32'h0000FFFF;
            tick();
        end
        idle();
        wbif.rs1_addr_i = 5'd1;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h00000104) begin n_err++; $display("FAIL jal_x1 got=%h exp=00000104", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.retired_count_o !== 32'd11) begin n_err++; $display("FAIL count_nowrite got=%h exp=0000000b", wbif.retired_count_o); end
    endtask

    task automatic test_wrap_and_reset_race();
        wbif.cnt_load_i     = 1'b1;
        wbif.cnt_load_val_i = 32'hFFFFFFFF;
        tick();
        idle();
        wbif.wb_valid_i = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (wbif.retired_count_o !== 32'h0) begin n_err++; $display("FAIL count_wrap got=%h exp=0", wbif.retired_count_o); end
        drive_write(5'd3, 2'b00, 32'h00000033);
        tick();
        drive_write(5'd3, 2'b00, 32'h00000099);
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if (wbif.wb_we_o !== 1'b0) begin n_err++; $display("FAIL race_we got=%0b exp=0", wbif.wb_we_o); end
        tick();
        reset_i = 1'b0;
        idle();
        wbif.rs1_addr_i = 5'd3;
        wbif.rs2_addr_i = 5'd5;
        #1;
        n_cmp++;
        if (wbif.rs1_data_o !== 32'h0) begin n_err++; $display("FAIL race_x3 got=%h exp=0", wbif.rs1_data_o); end
        n_cmp++;
        if (wbif.rs2_data_o !== 32'h0) begin n_err++; $display("FAIL race_x5 got=%h exp=0", wbif.rs2_data_o); end
        n_cmp++;
        if (wbif.retired_count_o !== 32'h0) begin n_err++; $display("FAIL race_count got=%h exp=0", wbif.retired_count_o); end
    endtask

    task automatic test_first_write_after_reset();
        drive_write(5'd3, 2'b00, 32'h00000003);
        tick();
        idle();
        wbif.rs2_addr_i = 5'd3;
        #1;
        n_cmp++;
        if (wbif.rs2_data_o !== 32'h00000003) begin n_err++; $display("FAIL first_write_x3 got=%h exp=00000003", wbif.rs2_data_o); end
        n_cmp++;
        if (wbif.retired_count_o !== 32'd1) begin n_err++; $display("FAIL first_write_count got=%h exp=1", wbif.retired_count_o); end
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        test_reset();
        test_basic_write();
        test_load_align();
        test_x0_and_nowrite();
        test_bypass();
        test_jal_and_counter();
        test_wrap_and_reset_race();
        test_first_write_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
